// File: rtl/ip_fetch_sequencer_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
package ip_fetch_sequencer_pkg;

    localparam int IADDR_W = 10;
    localparam int INSTR_W = 16;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } seq_state_e;

endpackage

// File: rtl/ip_fetch_buf.sv
// Two-entry prefetch FIFO of {address, instruction}; slot 0 is always the head,
// so the head fields come straight from registers.
module ip_fetch_buf
    import ip_fetch_sequencer_pkg::*;
#(
    parameter int            AW         = IADDR_W,
    parameter int            DW         = INSTR_W,
    parameter logic [AW-1:0] RESET_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [1:0]    count,
    output logic          head_valid,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data
);

    logic          v0_r, v1_r;
    logic [AW-1:0] a0_r, a1_r;
    logic [DW-1:0] d0_r, d1_r;

    // Slot update: shift slot 1 forward on pop; head fields hold when nothing replaces them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_r <= 1'b0;
            v1_r <= 1'b0;
            a0_r <= RESET_ADDR;
            a1_r <= '0;
            d0_r <= '0;
            d1_r <= '0;
        end else if (flush) begin
            v0_r <= 1'b0;
            v1_r <= 1'b0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (v1_r) begin
                        a0_r <= a1_r;
                        d0_r <= d1_r;
                        a1_r <= push_addr;
                        d1_r <= push_data;
                    end else begin
                        a0_r <= push_addr;
                        d0_r <= push_data;
                    end
                end
                2'b01: begin
                    v0_r <= v1_r;
                    v1_r <= 1'b0;
                    if (v1_r) begin
                        a0_r <= a1_r;
                        d0_r <= d1_r;
                    end
                end
                2'b10: begin
                    if (!v0_r) begin
                        v0_r <= 1'b1;
                        a0_r <= push_addr;
                        d0_r <= push_data;
                    end else begin
                        v1_r <= 1'b1;
                        a1_r <= push_addr;
                        d1_r <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count      = {1'b0, v0_r} + {1'b0, v1_r};
    assign head_valid = v0_r;
    assign head_addr  = a0_r;
    assign head_data  = d0_r;

endmodule

// File: rtl/ip_fetch_sequencer.sv
// Fetch sequencer: single-outstanding instruction fetch into a 2-entry prefetch
// buffer, with redirect handling that drains a stale in-flight request.
module ip_fetch_sequencer
    import ip_fetch_sequencer_pkg::*;
#(
    parameter int                     iaddr_width  = IADDR_W,
    parameter int                     instr_width  = INSTR_W,
    parameter logic [iaddr_width-1:0] reset_vector = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [iaddr_width-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [instr_width-1:0] imem_data,
    output logic                   instr_valid,
    output logic [instr_width-1:0] instr,
    output logic [iaddr_width-1:0] IP,
    input  logic                   ex_ready,
    input  logic                   redirect,
    input  logic [iaddr_width-1:0] redirect_addr
);

    localparam logic [iaddr_width-1:0] ADDR_ONE = {{(iaddr_width-1){1'b0}}, 1'b1};

    seq_state_e             state_r;
    logic                   pending_r;
    logic [iaddr_width-1:0] fetch_ip_r;
    logic [iaddr_width-1:0] req_addr_r;

    logic [1:0]             count_s;
    logic                   head_valid_s;
    logic                   consume_s;
    logic                   take_redirect_s;
    logic                   ack_s;
    logic                   push_s;
    logic [2:0]             occ_after_s;
    logic                   launch_s;
    logic [iaddr_width-1:0] launch_addr_s;

    assign consume_s       = head_valid_s & ex_ready & (state_r == RUN);
    assign take_redirect_s = consume_s & redirect;
    assign ack_s           = pending_r & imem_ack;
    assign push_s          = ack_s & (state_r == RUN) & ~take_redirect_s;
    assign occ_after_s     = {1'b0, count_s} - {2'b00, consume_s} + {2'b00, push_s};

    // Launch decision: an ack this cycle frees the single request slot for an immediate relaunch.
    always_comb begin
        launch_s      = 1'b0;
        launch_addr_s = fetch_ip_r;
        case (state_r)
            RUN: begin
                if (take_redirect_s) begin
                    launch_s      = ~pending_r | ack_s;
                    launch_addr_s = redirect_addr;
                end else begin
                    launch_s      = (~pending_r | ack_s) & (occ_after_s < 3'd2);
                    launch_addr_s = fetch_ip_r;
                end
            end
            FLUSH: begin
                launch_s      = ack_s;
                launch_addr_s = fetch_ip_r;
            end
            default: begin
                launch_s      = 1'b0;
                launch_addr_s = fetch_ip_r;
            end
        endcase
    end

    // Sequencer state: FSM, outstanding-request flag and fetch address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RUN;
            pending_r  <= 1'b0;
            fetch_ip_r <= reset_vector;
            req_addr_r <= reset_vector;
        end else begin
            if (launch_s) begin
                pending_r  <= 1'b1;
                req_addr_r <= launch_addr_s;
                fetch_ip_r <= launch_addr_s + ADDR_ONE;
            end else begin
                if (ack_s) begin
                    pending_r <= 1'b0;
                end
                if (take_redirect_s) begin
                    fetch_ip_r <= redirect_addr;
                end
            end
            case (state_r)
                RUN: begin
                    if (take_redirect_s && pending_r && !imem_ack) begin
                        state_r <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (ack_s) begin
                        state_r <= RUN;
                    end
                end
                default: state_r <= RUN;
            endcase
        end
    end

    ip_fetch_buf #(
        .AW         (iaddr_width),
        .DW         (instr_width),
        .RESET_ADDR (reset_vector)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_addr  (req_addr_r),
        .push_data  (imem_data),
        .pop        (consume_s),
        .flush      (take_redirect_s),
        .count      (count_s),
        .head_valid (head_valid_s),
        .head_addr  (IP),
        .head_data  (instr)
    );

    assign imem_req    = pending_r;
    assign imem_addr   = req_addr_r;
    assign instr_valid = head_valid_s;

endmodule

// File: tb/tb_ip_fetch_sequencer.sv
// Self-checking bench for ip_fetch_sequencer: directed scenarios plus a random
// run checked against an architectural model of the executed address stream.
module tb_ip_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        ex_ready;
    logic        redirect;
    logic [9:0]  redirect_addr;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic [15:0] instr;
    logic [9:0]  ip;

    logic        req2;
    logic [9:0]  addr2;
    logic        ack2;
    logic [15:0] data2;
    logic        valid2;
    logic [15:0] instr2;
    logic [9:0]  ip2;

    int total;
    int bad;
    int lat;
    int wcnt;

    function automatic logic [15:0] mem_word(input logic [9:0] a);
        return {a[5:0], a} ^ 16'hA5C3;
    endfunction

    ip_fetch_sequencer dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .instr_valid(instr_valid),
        .instr(instr), .IP(ip), .ex_ready(ex_ready), .redirect(redirect),
        .redirect_addr(redirect_addr)
    );

    ip_fetch_sequencer #(.reset_vector(10'h3FE)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_data(data2), .instr_valid(valid2),
        .instr(instr2), .IP(ip2), .ex_ready(1'b1), .redirect(1'b0),
        .redirect_addr(10'h000)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with a programmable number of wait cycles before ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign imem_ack  = imem_req && (wcnt >= lat);
    assign imem_data = mem_word(imem_addr);
    assign ack2      = req2;
    assign data2     = mem_word(addr2);

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        lat = 0; ex_ready = 1'b1; redirect = 1'b0; redirect_addr = 10'h000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b want=0", imem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", instr_valid); end
        total++; if (ip !== 10'h000) begin bad++; $display("FAIL rst_ip got=%h want=000", ip); end
        total++; if (instr !== 16'h0000) begin bad++; $display("FAIL rst_instr got=%h want=0000", instr); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
            bad++; $display("FAIL first_req got req=%0b addr=%h want req=1 addr=000", imem_req, imem_addr);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (instr_valid !== 1'b1 || ip !== 10'(k) || instr !== mem_word(10'(k))) begin
                bad++; $display("FAIL stream_ip got v=%0b ip=%h instr=%h want v=1 ip=%h", instr_valid, ip, instr, 10'(k));
            end
        end
    endtask

    task automatic test_wrap();
        logic [9:0] exp;
        lat = 0; ex_ready = 1'b1; redirect = 1'b0;
        do_reset();
        @(negedge clk);
        exp = 10'h3FE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (valid2 !== 1'b1 || ip2 !== exp || instr2 !== mem_word(exp)) begin
                bad++; $display("FAIL wrap_ip got v=%0b ip=%h want ip=%h", valid2, ip2, exp);
            end
            exp = exp + 10'h001;
        end
    endtask

    task automatic test_stall();
        logic [9:0] next_fetch;
        logic [9:0] exp;
        int got;
        lat = 0; ex_ready = 1'b0; redirect = 1'b0;
        do_reset();
        next_fetch = 10'h000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (imem_req && imem_ack) begin
                total++; if (imem_addr !== next_fetch) begin
                    bad++; $display("FAIL stall_seq got=%h want=%h", imem_addr, next_fetch);
                end
                next_fetch = next_fetch + 10'h001;
            end
        end
        total++; if (instr_valid !== 1'b1 || ip !== 10'h000) begin
            bad++; $display("FAIL stall_head got v=%0b ip=%h want v=1 ip=000", instr_valid, ip);
        end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%0b want=0", imem_req); end
        total++; if (next_fetch !== 10'h002) begin bad++; $display("FAIL stall_fills got=%0d want=2", next_fetch); end
        ex_ready = 1'b1;
        exp = 10'h000; got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (instr_valid) begin
                total++; if (ip !== exp || instr !== mem_word(exp)) begin
                    bad++; $display("FAIL stall_drain got ip=%h instr=%h want ip=%h", ip, instr, exp);
                end
                exp = exp + 10'h001; got++;
            end
            if (imem_req && imem_ack) begin
                total++; if (imem_addr !== next_fetch) begin
                    bad++; $display("FAIL stall_seq got=%h want=%h", imem_addr, next_fetch);
                end
                next_fetch = next_fetch + 10'h001;
            end
            @(negedge clk);
        end
        total++; if (got !== 3) begin bad++; $display("FAIL stall_timeout got=%0d want=3", got); end
    endtask

    task automatic test_redirect_flush();
        logic [9:0] old;
        int found;
        int seen;
        lat = 3; ex_ready = 1'b1; redirect = 1'b0;
        do_reset();
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            @(negedge clk);
            if (instr_valid && ip == 10'h004) found = 1;
        end
        total++; if (found !== 1) begin bad++; $display("FAIL flush_find got=%0d want=1", found); end
        total++; if (imem_req !== 1'b1 || imem_ack !== 1'b0) begin
            bad++; $display("FAIL flush_pre got req=%0b ack=%0b want req=1 ack=0", imem_req, imem_ack);
        end
        old = imem_addr;
        redirect = 1'b1; redirect_addr = 10'h200;
        @(negedge clk);
        redirect = 1'b0;
        total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== old) begin
            bad++; $display("FAIL flush_hold got v=%0b req=%0b addr=%h want v=0 req=1 addr=%h", instr_valid, imem_req, imem_addr, old);
        end
        found = 0; seen = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            @(negedge clk);
            if (imem_req && imem_addr != old && seen == 0) begin
                seen = 1;
                total++; if (imem_addr !== 10'h200) begin bad++; $display("FAIL flush_newreq got=%h want=200", imem_addr); end
            end
            if (instr_valid) begin
                found = 1;
                total++; if (ip !== 10'h200 || instr !== mem_word(10'h200)) begin
                    bad++; $display("FAIL flush_target got ip=%h instr=%h want ip=200", ip, instr);
                end
            end
        end
        total++; if (found !== 1) begin bad++; $display("FAIL flush_timeout got=%0d want=1", found); end
    endtask

    task automatic test_redirect_ack();
        int found;
        lat = 0; ex_ready = 1'b1; redirect = 1'b0;
        do_reset();
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (instr_valid && ip == 10'h003) found = 1;
        end
        total++; if (found !== 1 || imem_req !== 1'b1 || imem_ack !== 1'b1) begin
            bad++; $display("FAIL rda_pre got found=%0d req=%0b ack=%0b want 1 1 1", found, imem_req, imem_ack);
        end
        redirect = 1'b1; redirect_addr = 10'h155;
        @(negedge clk);
        redirect = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'h155 || instr_valid !== 1'b0) begin
            bad++; $display("FAIL rda_req got req=%0b addr=%h v=%0b want req=1 addr=155 v=0", imem_req, imem_addr, instr_valid);
        end
        @(negedge clk);
        total++; if (instr_valid !== 1'b1 || ip !== 10'h155 || instr !== mem_word(10'h155)) begin
            bad++; $display("FAIL rda_target got v=%0b ip=%h want v=1 ip=155", instr_valid, ip);
        end
    endtask

    task automatic test_reset_mid();
        int found;
        lat = 3; ex_ready = 1'b1; redirect = 1'b0;
        do_reset();
        found = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            @(negedge clk);
            if (instr_valid && imem_req && !imem_ack) found = 1;
        end
        total++; if (found !== 1) begin bad++; $display("FAIL rmid_find got=%0d want=1", found); end
        rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || ip !== 10'h000) begin
            bad++; $display("FAIL rmid_async got req=%0b v=%0b ip=%h want 0 0 000", imem_req, instr_valid, ip);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
            bad++; $display("FAIL rmid_restart got req=%0b addr=%h want req=1 addr=000", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        logic [9:0] exp_ip;
        logic [9:0] prev_addr;
        logic       hold_prev;
        int         consumes;
        lat = 0; ex_ready = 1'b0; redirect = 1'b0;
        do_reset();
        exp_ip = 10'h000; hold_prev = 1'b0; prev_addr = 10'h000; consumes = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c % 50 == 0) lat = int'($urandom_range(0, 3));
            ex_ready      = ($urandom_range(0, 3) != 0);
            redirect      = ($urandom_range(0, 7) == 0);
            redirect_addr = 10'($urandom);
            #1;
            if (hold_prev) begin
                total++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    bad++; $display("FAIL rnd_stable got req=%0b addr=%h want req=1 addr=%h", imem_req, imem_addr, prev_addr);
                end
            end
            if (instr_valid && ex_ready) begin
                total++; if (ip !== exp_ip || instr !== mem_word(exp_ip)) begin
                    bad++; $display("FAIL rnd_consume got ip=%h instr=%h want ip=%h instr=%h", ip, instr, exp_ip, mem_word(exp_ip));
                end
                exp_ip = redirect ? redirect_addr : exp_ip + 10'h001;
                consumes++;
            end
            hold_prev = imem_req && !imem_ack;
            prev_addr = imem_addr;
        end
        redirect = 1'b0;
        total++; if (consumes < 200) begin bad++; $display("FAIL rnd_progress got=%0d want>=200", consumes); end
    endtask

    initial begin
        total = 0; bad = 0; lat = 0;
        rst = 1'b1; ex_ready = 1'b0; redirect = 1'b0; redirect_addr = 10'h000;
        test_reset();
        test_wrap();
        test_stall();
        test_redirect_flush();
        test_redirect_ack();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
